instruction_loader: RTL

- Write-side counterpart of the InstructionMemory read port; fills program memory from a byte stream (debug UART/host link).
- Parses a framed download (sync, start address, word count, payload) and drives a single-port memory write interface.
- Holds the core in reset (cpu_hold) while loading.
- Sits between the host byte receiver and the instruction memory write port.

---
 rtl/instruction_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Loads instruction memory from a framed byte stream: SYNC, 2-byte start address, 2-byte word count, then
// 3 big-endian bytes per word. The CPU is held in reset while a frame is in progress.
module instruction_loader #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned DATA_W    = 19,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              load_err
);

   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam int unsigned D0_W      = DATA_W - 16;
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_SYNC,
      S_ADDR_HI,
      S_ADDR_LO,
      S_CNT_HI,
      S_CNT_LO,
      S_D0,
      S_D1,
      S_D2
   } state_e;

   // Error is a separate one-cycle state so in_ready can be derived directly from the state register.
   state_e              state_q,     state_d;
   logic                err_q,       err_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [7:0]          cnt_hi_q,    cnt_hi_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic [D0_W-1:0]     d0_q,        d0_d;
   logic [7:0]          d1_q,        d1_d;
   logic                mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                load_err_q,  load_err_d;

   logic                accept;
   logic                go_err;
   logic [15:0]         hdr16;

   assign in_ready = ~err_q;
   assign accept   = in_valid & ~err_q;

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
      state_d     = state_q;
      err_d       = 1'b0;
      addr_d      = addr_q;
      cnt_hi_d    = cnt_hi_q;
      cnt_d       = cnt_q;
      d0_d        = d0_q;
      d1_d        = d1_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = busy_q & ~done_q;
      done_d      = 1'b0;
      load_err_d  = load_err_q;
      go_err      = 1'b0;
      hdr16       = 16'h0000;

      if (accept) begin
         unique case (state_q)
            S_SYNC: begin
               if (in_data == SYNC_BYTE) begin
                  state_d    = S_ADDR_HI;
                  busy_d     = 1'b1;
                  load_err_d = 1'b0;
               end
            end
            S_ADDR_HI: begin
               hdr16 = {in_data, 8'h00};
               if ((hdr16 >> ADDR_W) != 16'h0000) begin
                  go_err = 1'b1;
               end else begin
                  addr_d  = hdr16[ADDR_W-1:0];
                  state_d = S_ADDR_LO;
               end
            end
            S_ADDR_LO: begin
               addr_d  = addr_q | ADDR_W'(in_data);
               state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
               cnt_hi_d = in_data;
               state_d  = S_CNT_LO;
            end
            S_CNT_LO: begin
               hdr16 = {cnt_hi_q, in_data};
               if (hdr16 == 16'h0000) begin
                  state_d = S_SYNC;
                  done_d  = 1'b1;
               end else if ({1'b0, hdr16} > MAX_WORDS) begin
                  go_err = 1'b1;
               end else begin
                  cnt_d   = hdr16[CNT_W-1:0];
                  state_d = S_D0;
               end
            end
            S_D0: begin
               d0_d    = in_data[D0_W-1:0];
               state_d = S_D1;
            end
            S_D1: begin
               d1_d    = in_data;
               state_d = S_D2;
            end
            S_D2: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = {d0_q, d1_q, in_data};
               addr_d      = addr_q + ADDR_W'(1);
               cnt_d       = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_SYNC;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_D0;
               end
            end
            default: state_d = S_SYNC;
         endcase
      end

      if (go_err) begin
         state_d    = S_SYNC;
         err_d      = 1'b1;
         busy_d     = 1'b0;
         load_err_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_SYNC;
         err_q       <= 1'b0;
         addr_q      <= '0;
         cnt_hi_q    <= '0;
         cnt_q       <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         cnt_hi_q    <= cnt_hi_d;
         cnt_q       <= cnt_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign cpu_hold  = busy_q;
   assign done      = done_q;
   assign load_err  = load_err_q;

endmodule
